inst_sequencer: RTL and testbench
=================================

// Module: inst_sequencer
// PURPOSE
//  Multicycle control FSM for the soft processor core: fetches a 32-bit word from instruction memory,
//  holds it in the instruction register (ir) that drives the field splitter, then steps through
//  EXEC / MEM / WB, asserting datapath enables and updating the PC. Sits between imem, dmem handshake
//  and the splitter/ALU/regfile datapath; it is the only writer of pc and ir.
// PARAMETERS
//  ADDR_W    32   width of pc / imem_addr
//  RESET_PC  0    pc value loaded on reset
//  PC_STEP   4    sequential pc increment (byte addressed)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  imem_req       out  1       fetch request, held until imem_ack
//  imem_addr      out  ADDR_W  fetch address (= pc)
//  imem_rdata     in   32      fetched word, valid with imem_ack
//  imem_ack       in   1       fetch complete; sampled only in FETCH
//  dmem_ack       in   1       data access complete; sampled only in MEM
//  branch_taken   in   1       ALU compare result, sampled in EXEC
//  ir             out  32      instruction register, drives splitter inst
//  ir_valid       out  1       ir holds a decoded-ready instruction (DECODE..WB)
//  alu_en         out  1       ALU operand/result capture strobe (EXEC, 1 cycle)
//  dmem_req       out  1       data access request (MEM, held until dmem_ack)
//  dmem_we        out  1       store qualifier, valid with dmem_req
//  reg_we         out  1       register file write strobe (WB, 1 cycle)
//  halted         out  1       HALT reached
//  retire_cnt     out  32      instructions completed, wraps 0xFFFF_FFFF -> 0
// BEHAVIOUR
//  Reset (async, immediate): state=FETCH, pc=RESET_PC, ir=0, retire_cnt=0; all strobes, imem_req,
//   dmem_req, ir_valid, halted = 0. imem_req rises the first clk after rst deasserts.
//  States: FETCH, DECODE, EXEC, MEM, WB, HALT (one-hot or binary, implementer's choice).
//  FETCH: imem_req=1. On imem_ack: ir<=imem_rdata, -> DECODE. No ack: stay, pc/ir unchanged.
//  DECODE (1 cycle): ir_valid=1. opcode=ir[31:26]:
//   HALT -> HALT; J -> pc<={pc[ADDR_W-1:28], ir[25:0], 2'b00}, -> FETCH, retire++;
//   otherwise -> EXEC.
//  EXEC (1 cycle): alu_en=1. BEQ: pc <= taken ? pc+PC_STEP+(sext(ir[15:0])<<2) : pc+PC_STEP,
//   retire++, -> FETCH. LW/SW -> MEM. R-type/ADDI -> WB. Unknown opcode: treated as NOP,
//   pc+=PC_STEP, retire++, -> FETCH.
//  MEM: dmem_req=1, dmem_we=(SW). On dmem_ack: SW -> pc+=PC_STEP, retire++, FETCH; LW -> WB.
//  WB (1 cycle): reg_we=1, pc+=PC_STEP, retire++, -> FETCH.
//  HALT: terminal; halted=1, all requests 0; only rst leaves it.
//  Latency: min 4 cycles (J), 5 (BEQ/NOP), 6 (R/ADDI, SW with 0-wait ack), 7+ (LW).
//  PC arithmetic modulo 2^ADDR_W; branch offset sign-extended to ADDR_W; wrap silently.
//  Acks outside their state are ignored; ack in the same cycle req first rises is accepted.
//  rst mid-fetch/mid-MEM: requests drop the same instant; stale late acks after reset ignored.
//  ir stable from DECODE until next FETCH completes; retire_cnt increments exactly once per
//  completed instruction, never for HALT.
// STRUCTURE
//  Shared package isa_pkg: opcode constants (R=6'h00, J=6'h02, BEQ=6'h04, ADDI=6'h08,
//   LW=6'h23, SW=6'h2B, HALT=6'h3F) and state encoding localparams.
//  One sub-module: pc_next_calc (combinational: sequential, branch, jump target).
//  FSM, ir, pc and retire_cnt registers in this module.
// TESTING
//  R-type 0x012A4020 at pc 0, 0-wait imem -> reg_we pulses cycle 5, pc=4, retire_cnt=1.
//  BEQ 0x1000FFFF with branch_taken=1 at pc 8 -> pc=8 (8+4-4), no reg_we, retire_cnt+1.
//  LW 0x8C080004, dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, then reg_we.
//  J 0x08000010 at pc 0x1000_0000 -> pc=0x1000_0040 after DECODE, alu_en never asserted.
//  rst asserted mid-MEM of SW -> dmem_req/ir_valid 0 asynchronously; pc=RESET_PC, refetch at 0.
//  HALT 0xFC000000 -> halted=1 permanently, imem_req 0, retire_cnt unchanged; 0xFFFF_FFFF wrap check.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA constants and sequencer state type for the soft processor core.
package isa_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Candidate next-pc values: sequential, taken branch and jump target.
module pc_next_calc #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned PC_STEP = 4
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       imm16,
  input  logic [25:0]       target26,
  output logic [ADDR_W-1:0] pc_seq,
  output logic [ADDR_W-1:0] pc_br,
  output logic [ADDR_W-1:0] pc_jmp
);

  logic [ADDR_W-1:0] br_off;

  // Word offset sign-extended to pc width; all sums wrap modulo 2^ADDR_W.
  always_comb begin
    br_off = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
    pc_seq = pc + ADDR_W'(PC_STEP);
    pc_br  = pc_seq + br_off;
    pc_jmp = {pc[ADDR_W-1:28], target26, 2'b00};
  end

endmodule

// File: rtl/inst_sequencer.sv
// Multicycle control sequencer: fetch into ir, then EXEC/MEM/WB with
// datapath strobes; sole owner of pc, ir and the retired-instruction count.
module inst_sequencer
  import isa_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  input  logic              dmem_ack,
  input  logic              branch_taken,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic              alu_en,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic              reg_we,
  output logic              halted,
  output logic [31:0]       retire_cnt
);

  state_t            state, ns;
  logic [ADDR_W-1:0] pc, pc_d;
  logic [ADDR_W-1:0] pc_seq, pc_br, pc_jmp;
  logic [5:0]        opcode;
  logic              ir_load, retire;

  assign opcode    = ir[31:26];
  assign imem_addr = pc;

  pc_next_calc #(
    .ADDR_W  (ADDR_W),
    .PC_STEP (PC_STEP)
  ) u_pc_next (
    .pc       (pc),
    .imm16    (ir[15:0]),
    .target26 (ir[25:0]),
    .pc_seq   (pc_seq),
    .pc_br    (pc_br),
    .pc_jmp   (pc_jmp)
  );

  // Next state, pc update and retire decision for the current cycle.
  // imem_ack is only honoured while imem_req is actually driven, so an ack
  // left over from before reset cannot complete a fetch in the idle cycle.
  always_comb begin
    ns      = state;
    pc_d    = pc;
    ir_load = 1'b0;
    retire  = 1'b0;
    case (state)
      S_FETCH: begin
        if (imem_req && imem_ack) begin
          ir_load = 1'b1;
          ns      = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          ns = S_HALT;
        end else if (opcode == OP_J) begin
          pc_d   = pc_jmp;
          retire = 1'b1;
          ns     = S_FETCH;
        end else begin
          ns = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_BEQ: begin
            pc_d   = branch_taken ? pc_br : pc_seq;
            retire = 1'b1;
            ns     = S_FETCH;
          end
          OP_LW, OP_SW: ns = S_MEM;
          OP_R, OP_ADDI: ns = S_WB;
          default: begin
            pc_d   = pc_seq;
            retire = 1'b1;
            ns     = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (opcode == OP_SW) begin
            pc_d   = pc_seq;
            retire = 1'b1;
            ns     = S_FETCH;
          end else begin
            ns = S_WB;
          end
        end
      end
      S_WB: begin
        pc_d   = pc_seq;
        retire = 1'b1;
        ns     = S_FETCH;
      end
      default: ns = S_HALT;
    endcase
  end

  // State, architectural registers and outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      retire_cnt <= '0;
      imem_req   <= 1'b0;
      ir_valid   <= 1'b0;
      alu_en     <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      reg_we     <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state <= ns;
      pc    <= pc_d;
      if (ir_load) ir <= imem_rdata;
      if (retire) retire_cnt <= retire_cnt + 32'd1;
      imem_req <= (ns == S_FETCH);
      ir_valid <= (ns == S_DECODE) || (ns == S_EXEC) || (ns == S_MEM) || (ns == S_WB);
      alu_en   <= (ns == S_EXEC);
      dmem_req <= (ns == S_MEM);
      dmem_we  <= (ns == S_MEM) && (opcode == OP_SW);
      reg_we   <= (ns == S_WB);
      halted   <= (ns == S_HALT);
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer.
module tb_inst_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        dmem_ack;
  logic        branch_taken;
  logic [31:0] ir;
  logic        ir_valid, alu_en, dmem_req, dmem_we, reg_we, halted;
  logic [31:0] retire_cnt;

  logic        hi_imem_req;
  logic [31:0] hi_imem_addr;
  logic [31:0] hi_imem_rdata;
  logic        hi_imem_ack;
  logic [31:0] hi_ir;
  logic        hi_ir_valid, hi_alu_en, hi_dmem_req, hi_dmem_we, hi_reg_we, hi_halted;
  logic [31:0] hi_retire_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .dmem_ack     (dmem_ack),
    .branch_taken (branch_taken),
    .ir           (ir),
    .ir_valid     (ir_valid),
    .alu_en       (alu_en),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .reg_we       (reg_we),
    .halted       (halted),
    .retire_cnt   (retire_cnt)
  );

  // Second instance whose pc starts in the upper region, for jump targets.
  inst_sequencer #(
    .ADDR_W   (32),
    .RESET_PC (32'h1000_0000),
    .PC_STEP  (4)
  ) dut_hi (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (hi_imem_req),
    .imem_addr    (hi_imem_addr),
    .imem_rdata   (hi_imem_rdata),
    .imem_ack     (hi_imem_ack),
    .dmem_ack     (1'b0),
    .branch_taken (1'b0),
    .ir           (hi_ir),
    .ir_valid     (hi_ir_valid),
    .alu_en       (hi_alu_en),
    .dmem_req     (hi_dmem_req),
    .dmem_we      (hi_dmem_we),
    .reg_we       (hi_reg_we),
    .halted       (hi_halted),
    .retire_cnt   (hi_retire_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one word with a single-cycle ack; returns in DECODE.
  task automatic fetch(input logic [31:0] w);
    imem_rdata = w;
    imem_ack   = 1'b1;
    tick();
    imem_ack   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; imem_rdata = '0; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
    hi_imem_rdata = '0; hi_imem_ack = 1'b0;
    #12;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_pc", imem_addr, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_hi_pc", hi_imem_addr, 32'h1000_0000);
    rst = 1'b0;
    tick();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // R-type at pc 0
    fetch(32'h012A_4020);
    chk("r_ir", ir, 32'h012A_4020);
    chk("r_ir_valid", 32'(ir_valid), 32'd1);
    chk("r_dec_req", 32'(imem_req), 32'd0);
    chk("r_dec_alu", 32'(alu_en), 32'd0);
    tick();
    chk("r_exec_alu", 32'(alu_en), 32'd1);
    chk("r_exec_regwe", 32'(reg_we), 32'd0);
    tick();
    chk("r_wb_regwe", 32'(reg_we), 32'd1);
    chk("r_wb_alu", 32'(alu_en), 32'd0);
    chk("r_wb_pc", imem_addr, 32'h0);
    tick();
    chk("r_done_regwe", 32'(reg_we), 32'd0);
    chk("r_done_pc", imem_addr, 32'h4);
    chk("r_done_retire", retire_cnt, 32'd1);
    chk("r_done_req", 32'(imem_req), 32'd1);
    chk("r_done_ir_valid", 32'(ir_valid), 32'd0);

    // Unknown opcode behaves as NOP
    fetch(32'hF800_0000);
    tick();
    chk("nop_alu", 32'(alu_en), 32'd1);
    tick();
    chk("nop_pc", imem_addr, 32'h8);
    chk("nop_retire", retire_cnt, 32'd2);
    chk("nop_regwe", 32'(reg_we), 32'd0);

    // BEQ taken, offset -1 word
    branch_taken = 1'b1;
    fetch(32'h1000_FFFF);
    tick();
    tick();
    chk("beq_t_pc", imem_addr, 32'h8);
    chk("beq_t_retire", retire_cnt, 32'd3);
    chk("beq_t_regwe", 32'(reg_we), 32'd0);
    // BEQ not taken
    branch_taken = 1'b0;
    fetch(32'h1000_FFFF);
    tick();
    tick();
    chk("beq_nt_pc", imem_addr, 32'hC);
    chk("beq_nt_retire", retire_cnt, 32'd4);

    // LW with three wait cycles before dmem_ack
    fetch(32'h8C08_0004);
    tick();
    tick();
    chk("lw_we", 32'(dmem_we), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("lw_req_wait", 32'(dmem_req), 32'd1);
      chk("lw_wait_regwe", 32'(reg_we), 32'd0);
      tick();
    end
    dmem_ack = 1'b1;
    chk("lw_req_ack", 32'(dmem_req), 32'd1);
    tick();
    dmem_ack = 1'b0;
    chk("lw_wb_req", 32'(dmem_req), 32'd0);
    chk("lw_wb_regwe", 32'(reg_we), 32'd1);
    tick();
    chk("lw_pc", imem_addr, 32'h10);
    chk("lw_retire", retire_cnt, 32'd5);

    // SW with 0-wait ack
    fetch(32'hAC08_0004);
    tick();
    tick();
    chk("sw_req", 32'(dmem_req), 32'd1);
    chk("sw_we", 32'(dmem_we), 32'd1);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("sw_pc", imem_addr, 32'h14);
    chk("sw_retire", retire_cnt, 32'd6);
    chk("sw_regwe", 32'(reg_we), 32'd0);
    chk("sw_req_drop", 32'(dmem_req), 32'd0);

    // Counter wrap on a J retire
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    chk("wrap_preset", retire_cnt, 32'hFFFF_FFFF);
    fetch(32'h0800_0010);
    chk("j_dec_alu", 32'(alu_en), 32'd0);
    tick();
    chk("j_pc", imem_addr, 32'h40);
    chk("j_wrap_retire", retire_cnt, 32'h0);
    chk("j_alu", 32'(alu_en), 32'd0);
    chk("j_req", 32'(imem_req), 32'd1);

    // HALT is terminal and does not retire
    fetch(32'hFC00_0000);
    chk("halt_dec_valid", 32'(ir_valid), 32'd1);
    tick();
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_dreq", 32'(dmem_req), 32'd0);
      chk("halt_retire", retire_cnt, 32'h0);
      chk("halt_pc", imem_addr, 32'h40);
      tick();
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;

    // Reset leaves HALT; then reset in the middle of an SW MEM phase
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_halted", 32'(halted), 32'd0);
    tick();
    chk("rst2_req", 32'(imem_req), 32'd1);
    chk("rst2_addr", imem_addr, 32'h0);
    fetch(32'hAC08_0004);
    tick();
    tick();
    chk("mid_mem_req", 32'(dmem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_dreq", 32'(dmem_req), 32'd0);
    chk("mid_rst_valid", 32'(ir_valid), 32'd0);
    chk("mid_rst_we", 32'(dmem_we), 32'd0);
    chk("mid_rst_pc", imem_addr, 32'h0);
    chk("mid_rst_ir", ir, 32'h0);
    dmem_ack = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_addr", imem_addr, 32'h0);
    chk("refetch_dreq", 32'(dmem_req), 32'd0);
    chk("refetch_retire", retire_cnt, 32'h0);
    dmem_ack = 1'b0;

    // J on the high-pc instance keeps upper pc bits
    chk("hi_start_pc", hi_imem_addr, 32'h1000_0000);
    hi_imem_rdata = 32'h0800_0010;
    hi_imem_ack   = 1'b1;
    tick();
    hi_imem_ack   = 1'b0;
    chk("hi_dec_valid", 32'(hi_ir_valid), 32'd1);
    chk("hi_dec_alu", 32'(hi_alu_en), 32'd0);
    tick();
    chk("hi_j_pc", hi_imem_addr, 32'h1000_0040);
    chk("hi_j_retire", hi_retire_cnt, 32'd1);
    chk("hi_j_alu", 32'(hi_alu_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
